// File: rtl/sensor_init_pkg.sv
// Shared constants for the sensor init sequencer: FSM state encoding and
// the width helper used to size counters and indices.
package sensor_init_pkg;

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_GO       = 3'd1;
  localparam logic [2:0] S_WAIT_RSP = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Bits needed to index v items (never less than 1).
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_init_seq_timer.sv
// Shared saturating down-counter for power-on delay, response timeout and
// inter-pulse gap. The count stops at 0 instead of wrapping.
module init_timer #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [W-1:0] load_val,
  input  logic         load,
  output logic         expire
);

  logic [W-1:0] count;

  // Load on strobe, otherwise count down and hold at zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)             count <= W'(RST_VAL);
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  // High in the cycle whose closing edge takes the count to zero, so a
  // load of N gives exactly N cycles before the owner moves on.
  assign expire = (count <= W'(1));

endmodule

// File: rtl/sensor_init_seq.sv
// Power-on sequencer for a set of sensor init engines: waits out the power
// delay, then starts each engine in turn with retries, timeouts and gaps.
module sensor_init_seq
  import sensor_init_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DLY_CYC   = 60000,
  parameter int TMO_CYC   = 1000000,
  parameter int GAP_CYC   = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        restart,
  input  logic [N_CH-1:0]             ch_done,
  input  logic [N_CH-1:0]             ch_err,
  output logic [N_CH-1:0]             ch_go,
  output logic                        busy,
  output logic                        init_done,
  output logic                        all_ok,
  output logic [N_CH-1:0]             fail_mask,
  output logic [clog2_min1(N_CH)-1:0] cur_ch
);

  localparam int CW = clog2_min1(N_CH);
  localparam int AW = clog2_min1(MAX_RETRY + 1);
  localparam int TW = clog2_min1(max3(DLY_CYC, TMO_CYC, GAP_CYC) + 1);

  logic [2:0]      state, state_n;
  logic [CW-1:0]   cur_n;
  logic [AW-1:0]   attempts, att_n;
  logic [N_CH-1:0] mask_n;
  logic            done_n;
  logic            tmr_load, tmr_exp;
  logic [TW-1:0]   tmr_val;
  logic            rsp_done, rsp_err, fail;

  assign rsp_done = ch_done[cur_ch];
  assign rsp_err  = ch_err[cur_ch];

  init_timer #(.W(TW), .RST_VAL(DLY_CYC)) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load_val (tmr_val),
    .load     (tmr_load),
    .expire   (tmr_exp)
  );

  // Next-state, channel/attempt bookkeeping and timer reload decisions.
  always_comb begin
    state_n  = state;
    cur_n    = cur_ch;
    att_n    = attempts;
    mask_n   = fail_mask;
    done_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(GAP_CYC);
    fail     = 1'b0;
    case (state)
      S_PWR_WAIT: if (tmr_exp) state_n = S_GO;
      S_GO: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TMO_CYC);
        state_n  = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        // Error beats done; silence until the timer runs out is a failure.
        fail = rsp_err || (!rsp_done && tmr_exp);
        if (fail && (attempts < AW'(MAX_RETRY))) begin
          att_n    = attempts + 1'b1;
          tmr_load = 1'b1;
          state_n  = S_GAP;
        end else if (fail || rsp_done) begin
          if (fail) mask_n[cur_ch] = 1'b1;
          att_n = AW'(1);
          if (cur_ch == CW'(N_CH - 1)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            cur_n    = cur_ch + 1'b1;
            tmr_load = 1'b1;
            state_n  = S_GAP;
          end
        end
      end
      S_GAP: if (tmr_exp) state_n = S_GO;
      S_DONE: begin
        // Re-run skips the power delay and starts with a normal gap.
        if (restart) begin
          mask_n   = '0;
          cur_n    = '0;
          att_n    = AW'(1);
          tmr_load = 1'b1;
          state_n  = S_GAP;
        end
      end
      default: state_n = S_PWR_WAIT;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_PWR_WAIT;
      cur_ch    <= '0;
      attempts  <= AW'(1);
      fail_mask <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cur_ch    <= cur_n;
      attempts  <= att_n;
      fail_mask <= mask_n;
      init_done <= done_n;
    end
  end

  // Start pulse decoded from registered state, so reset cannot glitch it.
  always_comb begin
    ch_go = '0;
    if (state == S_GO) ch_go[cur_ch] = 1'b1;
  end

  assign busy   = (state != S_DONE);
  assign all_ok = (state == S_DONE) && (fail_mask == '0);

endmodule

// File: tb/tb_sensor_init_seq.sv
// Randomized bench for sensor_init_seq: a timeline model predicts every
// output each cycle; directed runs pin key latencies with literal values.
module tb_sensor_init_seq;

  localparam int N_CH = 2, DLY = 20, TMO = 50, GAP = 5, MAXR = 2;

  logic            clk = 1'b0, rst_n = 1'b1, restart = 1'b0;
  logic [N_CH-1:0] ch_done = '0, ch_err = '0;
  logic [N_CH-1:0] ch_go, fail_mask;
  logic            busy, init_done, all_ok;
  logic [0:0]      cur_ch;

  int n_chk = 0, n_fail = 0;

  sensor_init_seq #(.N_CH(N_CH), .DLY_CYC(DLY), .TMO_CYC(TMO), .GAP_CYC(GAP),
                    .MAX_RETRY(MAXR)) dut (
    .Clk(clk), .Rst_n(rst_n), .restart(restart), .ch_done(ch_done),
    .ch_err(ch_err), .ch_go(ch_go), .busy(busy), .init_done(init_done),
    .all_ok(all_ok), .fail_mask(fail_mask), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N_CH-1:0] e_go = '0, e_mask = '0;
  logic            e_busy = 1'b1, e_done = 1'b0, e_ok = 1'b0;
  int              e_cur = 0;
  bit              abort = 1'b0;

  always @(negedge rst_n) begin
    abort = 1'b1;
    e_go = '0; e_mask = '0; e_busy = 1'b1; e_done = 1'b0; e_ok = 1'b0; e_cur = 0;
  end

  task automatic step();
    @(posedge clk);
    if (!abort) e_done = 1'b0;
  endtask

  task automatic gap(input int c);
    repeat (GAP) begin step(); if (abort) return; end
    e_go = '0; e_go[c] = 1'b1;
  endtask

  task automatic model_seq();
    bit ok;
    e_go = '0; e_busy = 1'b1; e_ok = 1'b0; e_mask = '0; e_cur = 0;
    repeat (DLY) begin step(); if (abort) return; end
    e_go[0] = 1'b1;
    forever begin
      for (int c = 0; c < N_CH; c++) begin
        ok = 1'b0;
        for (int a = 1; a <= MAXR; a++) begin
          step(); if (abort) return;          // edge closing the go cycle
          e_go = '0;
          for (int t = 1; t <= TMO; t++) begin
            step(); if (abort) return;
            if (ch_err[c]) break;
            if (ch_done[c]) begin ok = 1'b1; break; end
          end
          if (ok) break;
          if (a < MAXR) begin gap(c); if (abort) return; end
        end
        if (!ok) e_mask[c] = 1'b1;
        if (c < N_CH - 1) begin
          e_cur = c + 1;
          gap(c + 1); if (abort) return;
        end
      end
      e_busy = 1'b0; e_done = 1'b1; e_ok = (e_mask == '0);
      do begin step(); if (abort) return; end while (!restart);
      e_busy = 1'b1; e_ok = 1'b0; e_mask = '0; e_cur = 0;
      gap(0); if (abort) return;
    end
  endtask

  initial begin
    @(negedge rst_n);
    forever begin
      wait (rst_n === 1'b1);
      abort = 1'b0;
      model_seq();
      wait (rst_n === 1'b0);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    n_chk++;
    if (ch_go !== e_go || busy !== e_busy || init_done !== e_done ||
        all_ok !== e_ok || fail_mask !== e_mask || int'(cur_ch) != e_cur) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL cycle_check t=%0t got go=%b busy=%b init_done=%b all_ok=%b mask=%b cur=%0d required go=%b busy=%b init_done=%b all_ok=%b mask=%b cur=%0d",
                 $time, ch_go, busy, init_done, all_ok, fail_mask, cur_ch,
                 e_go, e_busy, e_done, e_ok, e_mask, e_cur);
    end
  end

  // ---------------- responder ----------------
  // kinds: 0 done, 1 err, 2 done+err (plus done on every other channel), 3 silent
  int plan_k[$], plan_d[$];
  int pend_ch = 0, pend_cnt = 0, pend_k = 0, last_ch = 0, r = 0, o = 0;
  bit pend = 1'b0;

  initial forever begin
    @(posedge clk); #2;
    ch_done = '0; ch_err = '0;
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 1'b0;
          case (pend_k)
            0: ch_done[pend_ch] = 1'b1;
            1: ch_err[pend_ch] = 1'b1;
            2: begin ch_done = '1; ch_err[pend_ch] = 1'b1; end
            default: ;
          endcase
        end
      end
      if (ch_go != '0) begin
        for (int i = 0; i < N_CH; i++) if (ch_go[i]) pend_ch = i;
        if (plan_k.size() > 0) begin
          pend_k = plan_k.pop_front(); pend_cnt = plan_d.pop_front();
        end else begin
          r = $urandom_range(0, 9);
          pend_k = (r < 5) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
          pend_cnt = $urandom_range(1, TMO + 3);
        end
        pend = (pend_k != 3);
        last_ch = pend_ch;
      end
      // Stray pulses on channels that are not the one being waited on.
      if ($urandom_range(0, 7) == 0) begin
        o = $urandom_range(0, N_CH - 1);
        if (o != last_ch) begin
          if ($urandom_range(0, 1) == 1) ch_done[o] = 1'b1;
          else ch_err[o] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_restart();
    @(posedge clk); #2 restart = 1'b1;
    @(posedge clk); #2 restart = 1'b0;
  endtask

  task automatic wait_go(input int c, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!ch_go[c] && n < 2000);
    if (!ch_go[c]) check("wait_go_timeout", 0, 1);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!init_done && n < 3000);
    if (!init_done) check("wait_init_timeout", 0, 1);
  endtask

  task automatic set_plan(input int k0, input int d0, input int k1, input int d1,
                          input int k2, input int d2);
    plan_k = {k0, k1, k2}; plan_d = {d0, d1, d2};
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_busy", busy, 1);
    check("rst_go", ch_go, 0);
    check("rst_mask", fail_mask, 0);
    check("rst_all_ok", all_ok, 0);

    // Clean run: both channels answer done after 3 cycles.
    plan_k = {0, 0}; plan_d = {3, 3};
    rst_n = 1'b1; @(negedge clk);
    wait_go(0, n); check("pwr_delay", n, 20);
    wait_go(1, n); check("done_to_next_go", n, 9);
    wait_init();
    check("clean_all_ok", all_ok, 1);
    check("clean_mask", fail_mask, 0);
    check("clean_busy", busy, 0);

    // Channel 0 errors on both attempts.
    set_plan(1, 2, 1, 4, 0, 3);
    pulse_restart(); wait_init();
    check("err_mask", fail_mask, 1);
    check("err_all_ok", all_ok, 0);

    // Channel 1 never answers.
    set_plan(0, 2, 3, 1, 3, 1);
    pulse_restart(); wait_init();
    check("tmo_mask", fail_mask, 2);

    // done+err together on ch0 (with stray done on ch1) counts as a retry.
    set_plan(2, 3, 0, 3, 0, 3);
    pulse_restart(); wait_init();
    check("both_mask", fail_mask, 0);
    check("both_all_ok", all_ok, 1);

    // Restart from DONE, then an ignored restart mid-wait.
    plan_k = {0, 0}; plan_d = {10, 3};
    pulse_restart();
    wait_go(0, n); check("restart_to_go", n, 6);
    check("restart_mask_clear", fail_mask, 0);
    cyc(3); restart = 1'b1; cyc(1); restart = 1'b0;
    wait_init();
    check("mid_restart_mask", fail_mask, 0);

    // Reset two cycles after the ch1 go pulse.
    plan_k = {0, 3}; plan_d = {3, 1};
    pulse_restart();
    wait_go(1, n);
    cyc(2); rst_n = 1'b0;
    @(negedge clk);
    check("abort_go", ch_go, 0);
    check("abort_busy", busy, 1);
    check("abort_cur", cur_ch, 0);
    cyc(3); rst_n = 1'b1; @(negedge clk);
    wait_go(0, n); check("pwr_delay_again", n, 20);
    wait_init();

    // Randomized runs, sometimes with an extra restart pulse mid-run.
    for (int i = 0; i < 12; i++) begin
      cyc($urandom_range(0, 4));
      pulse_restart();
      if ($urandom_range(0, 1) == 1) begin
        cyc($urandom_range(1, 150));
        pulse_restart();
      end
      wait_init();
    end
    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sensor_init_seq.md
SENSOR_INIT_SEQ -- requirements
Module: sensor_init_seq

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of sensor init engines sequenced.
REQ-002 SHALL have parameter DLY_CYC, default 60000, power-on delay in Clk cycles.
REQ-003 SHALL have parameter TMO_CYC, default 1000000, per-attempt done timeout in cycles.
REQ-004 SHALL have parameter GAP_CYC, default 1000, idle gap before every go pulse after the first.
REQ-005 SHALL have parameter MAX_RETRY, default 3, total attempts allowed per channel (at least 1).
REQ-006 SHALL have port Clk, input, 1, clock.
REQ-007 SHALL have port Rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port restart, input, 1, pulse that re-runs the sequence from channel 0.
REQ-009 SHALL have port ch_done, input, N_CH, per-channel init-complete pulse.
REQ-010 SHALL have port ch_err, input, N_CH, per-channel init-error pulse (NACK or bus fault).
REQ-011 SHALL have port ch_go, output, N_CH, one-cycle start pulse per channel.
REQ-012 SHALL have port busy, output, 1, high from reset release until DONE.
REQ-013 SHALL have port init_done, output, 1, one-cycle pulse on entry to DONE.
REQ-014 SHALL have port all_ok, output, 1, high in DONE when fail_mask is zero.
REQ-015 SHALL have port fail_mask, output, N_CH, bit set when a channel exhausts its retries.
REQ-016 SHALL have port cur_ch, output, clog2(N_CH) (minimum 1), index of the active channel.

Function
REQ-017 SHALL implement states PWR_WAIT, GO, WAIT_RSP, GAP, DONE.
REQ-018 PWR_WAIT SHALL count DLY_CYC cycles after reset release; ch_go[0] SHALL be high for exactly one cycle, during the cycle following the DLY_CYC-th rising edge.
REQ-019 GO SHALL last one cycle, assert only ch_go[cur_ch], and then enter WAIT_RSP with the timeout counter cleared.
REQ-020 In WAIT_RSP, ch_done[cur_ch] high with ch_err[cur_ch] low SHALL be success; ch_err[cur_ch] high SHALL be failure, and err SHALL win when done and err are high in the same cycle.
REQ-021 WAIT_RSP with no response for TMO_CYC cycles SHALL be treated as failure.
REQ-022 ch_done and ch_err bits for any channel other than cur_ch, and all ch_done/ch_err in any state other than WAIT_RSP, SHALL be ignored.
REQ-023 On failure with attempts < MAX_RETRY, the block SHALL increment attempts and go to GAP, then GO on the same channel.
REQ-024 On failure with attempts = MAX_RETRY, the block SHALL set fail_mask[cur_ch] and advance to the next channel.
REQ-025 On success, the block SHALL advance to the next channel.
REQ-026 Advance SHALL reset attempts to 1; if cur_ch = N_CH-1 the block SHALL enter DONE, otherwise it SHALL increment cur_ch and go through GAP.
REQ-027 GAP SHALL last exactly GAP_CYC cycles, so the next ch_go pulse is high GAP_CYC+1 cycles after the response cycle.
REQ-028 DONE SHALL hold busy=0, hold fail_mask, and set all_ok=(fail_mask==0).
REQ-029 restart in DONE SHALL clear fail_mask and all_ok, set cur_ch=0 and busy=1, and enter GAP (no power delay).
REQ-030 restart in any state other than DONE SHALL be ignored.
REQ-031 Counters SHALL use one shared down-counter sized to clog2(max(DLY_CYC, TMO_CYC, GAP_CYC)+1) bits.
REQ-032 Counters SHALL NOT wrap; count value 0 SHALL be the expiry condition.

Reset
REQ-033 While Rst_n is low, the block SHALL hold state=PWR_WAIT, ch_go=0, busy=1, init_done=0, all_ok=0, fail_mask=0, cur_ch=0, attempts=1, counter=DLY_CYC.
REQ-034 Reset assertion mid-attempt SHALL abort immediately with no ch_go glitch; the sequence SHALL restart from PWR_WAIT on release.

Structure
REQ-035 A shared package sensor_init_pkg SHALL hold the state encoding constants and the clog2 helper.
REQ-036 A sub-module init_timer (load value, load strobe, expire flag) SHALL implement the shared down-counter.

Verification (N_CH=2, DLY_CYC=20, TMO_CYC=50, GAP_CYC=5, MAX_RETRY=2)
REQ-037 Release reset; ch_done[0] 3 cycles after ch_go[0]; ch_done[1] 3 cycles after ch_go[1] -> ch_go[0] after edge 20, ch_go[1] 6 cycles after the done cycle, init_done pulse, all_ok=1, fail_mask=00.
REQ-038 Drive ch_err[0] on both attempts -> two ch_go[0] pulses, fail_mask=01, ch_1 still started, all_ok=0.
REQ-039 Never respond on ch 1 -> ch_go[1] issued twice, each followed by 50 silent cycles, then fail_mask=10 and DONE.
REQ-040 Assert ch_done[0] and ch_err[0] in the same cycle, and ch_done[1] while cur_ch=0 -> treated as an error retry, the stray ch_done[1] ignored.
REQ-041 Pulse restart in DONE, and again mid-WAIT_RSP -> restart in DONE gives ch_go[0] 6 cycles later with fail_mask cleared; restart mid-WAIT_RSP has no effect.
REQ-042 Assert Rst_n low 2 cycles after ch_go[1] -> all outputs return to reset values; the next ch_go[0] comes after edge 20 following release.
